// File: rtl/max_argmax_stream_if.sv
// Handshake bundle for max_argmax_stream.
//   in_*  : beat stream (valid/ready, last, per-lane mask, P lanes of W-bit data)
//   out_* : per-vector result (valid/ready, max, argmax index, none and overflow flags)
// The master modport is the side that feeds beats and consumes results.
interface max_argmax_stream_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned P     = 8,
    parameter int unsigned IDX_W = 10
);
    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic [P-1:0]       in_lane_valid;
    logic [P*W-1:0]     in_data;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_max;
    logic [IDX_W-1:0]   out_idx;
    logic               out_none;
    logic               out_ovf;

    modport master (
        output in_valid, in_last, in_lane_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_idx, out_none, out_ovf
    );

    modport slave (
        input  in_valid, in_last, in_lane_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_idx, out_none, out_ovf
    );
endinterface

// File: rtl/max_argmax_stream.sv
// Streaming signed max/argmax reduction over vectors delivered as P-lane beats.
// Each beat goes through a registered log2(P)-level comparison tree, then a running
// accumulator merges beats until the last one, whose merged result is registered out.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : global enable; low freezes all state and holds in_ready low
//   bus   : slave side of max_argmax_stream_if (beat input, result output)
module max_argmax_stream #(
    parameter int unsigned W     = 16,
    parameter int unsigned P     = 8,
    parameter int unsigned IDX_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    max_argmax_stream_if.slave bus
);
    localparam int unsigned L  = $clog2(P);
    localparam int unsigned BW = IDX_W - L;
    localparam int unsigned CW = (BW > 0) ? BW : 1;
    localparam int unsigned NN = P - 1;   // internal tree nodes, heap order, root = 0
    localparam logic [CW-1:0] BeatMax = CW'(2 ** BW - 1);

    // Whole pipe moves together; a held result blocks everything upstream.
    logic advance, accept;
    assign advance      = en & ~(bus.out_valid & ~bus.out_ready);
    assign accept       = advance & bus.in_valid;
    assign bus.in_ready = advance;

    // Beat counter supplies the upper index bits; ovf_seen marks a wrap inside a vector.
    logic [CW-1:0]    beat_q, beat_d;
    logic             ovf_seen_q, ovf_seen_d;
    logic [IDX_W-1:0] beat_base;

    assign beat_base = IDX_W'(beat_q) << L;

    always_comb begin
        beat_d     = beat_q;
        ovf_seen_d = ovf_seen_q;
        if (accept) begin
            if (bus.in_last) begin
                beat_d     = '0;
                ovf_seen_d = 1'b0;
            end else if (beat_q == BeatMax) begin
                beat_d     = '0;
                ovf_seen_d = 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    // Heap-ordered tree: entries 0..NN-1 are registered nodes, NN..2P-2 are the lanes.
    // Left child always covers lower lanes, so ">=" sends ties to the lower lane.
    logic [2*P-2:0]   all_v;
    logic [W-1:0]     all_val [2*P-1];
    logic [IDX_W-1:0] all_idx [2*P-1];
    logic [NN-1:0]    node_v_q, node_v_d;
    logic [W-1:0]     node_val_q [NN];
    logic [W-1:0]     node_val_d [NN];
    logic [IDX_W-1:0] node_idx_q [NN];
    logic [IDX_W-1:0] node_idx_d [NN];

    always_comb begin
        for (int i = 0; i < NN; i++) begin
            all_v[i]   = node_v_q[i];
            all_val[i] = node_val_q[i];
            all_idx[i] = node_idx_q[i];
        end
        for (int k = 0; k < P; k++) begin
            all_v[NN+k]   = bus.in_valid & bus.in_lane_valid[k];
            all_val[NN+k] = bus.in_data[k*W +: W];
            all_idx[NN+k] = beat_base | IDX_W'(k);
        end
    end

    always_comb begin
        logic pick_a;
        pick_a = 1'b0;
        for (int i = 0; i < NN; i++) begin
            pick_a = all_v[2*i+1] &
                     (~all_v[2*i+2] | ($signed(all_val[2*i+1]) >= $signed(all_val[2*i+2])));
            node_v_d[i]   = all_v[2*i+1] | all_v[2*i+2];
            node_val_d[i] = pick_a ? all_val[2*i+1] : all_val[2*i+2];
            node_idx_d[i] = pick_a ? all_idx[2*i+1] : all_idx[2*i+2];
        end
    end

    // Beat valid/last/overflow tags, delayed to line up with the tree root.
    logic [L-1:0] bv_q, bl_q, bo_q;
    logic         root_beat, root_last;
    assign root_beat = bv_q[L-1];
    assign root_last = bl_q[L-1];

    // Accumulator merge with the root. An accumulator with no valid lane yet is
    // overwritten by any valid node; otherwise strict ">" keeps the earliest index.
    logic             acc_valid_q, acc_any_q;
    logic [W-1:0]     acc_max_q;
    logic [IDX_W-1:0] acc_idx_q;
    logic             take, m_any;
    logic [W-1:0]     m_max;
    logic [IDX_W-1:0] m_idx;

    always_comb begin
        take  = all_v[0] &
                (~acc_valid_q | ~acc_any_q | ($signed(all_val[0]) > $signed(acc_max_q)));
        m_any = acc_any_q | all_v[0];
        m_max = take ? all_val[0] : acc_max_q;
        m_idx = take ? all_idx[0] : acc_idx_q;
    end

    logic             out_valid_q, out_none_q, out_ovf_q;
    logic [W-1:0]     out_max_q;
    logic [IDX_W-1:0] out_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q      <= '0;
            ovf_seen_q  <= 1'b0;
            node_v_q    <= '0;
            for (int i = 0; i < NN; i++) begin
                node_val_q[i] <= '0;
                node_idx_q[i] <= '0;
            end
            bv_q        <= '0;
            bl_q        <= '0;
            bo_q        <= '0;
            acc_valid_q <= 1'b0;
            acc_any_q   <= 1'b0;
            acc_max_q   <= '0;
            acc_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_idx_q   <= '0;
            out_none_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else if (advance) begin
            beat_q     <= beat_d;
            ovf_seen_q <= ovf_seen_d;
            node_v_q   <= node_v_d;
            for (int i = 0; i < NN; i++) begin
                node_val_q[i] <= node_val_d[i];
                node_idx_q[i] <= node_idx_d[i];
            end
            bv_q[0] <= accept;
            bl_q[0] <= bus.in_last;
            bo_q[0] <= ovf_seen_q;
            for (int s = 1; s < L; s++) begin
                bv_q[s] <= bv_q[s-1];
                bl_q[s] <= bl_q[s-1];
                bo_q[s] <= bo_q[s-1];
            end
            if (root_beat) begin
                if (root_last) begin
                    acc_valid_q <= 1'b0;
                    acc_any_q   <= 1'b0;
                    acc_max_q   <= '0;
                    acc_idx_q   <= '0;
                end else begin
                    acc_valid_q <= 1'b1;
                    acc_any_q   <= m_any;
                    acc_max_q   <= m_max;
                    acc_idx_q   <= m_idx;
                end
            end
            // A new result wins over clearing the old one: no gap cycle.
            if (root_beat && root_last) begin
                out_valid_q <= 1'b1;
                out_max_q   <= m_max;
                out_idx_q   <= m_idx;
                out_none_q  <= ~m_any;
                out_ovf_q   <= bo_q[L-1];
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_max   = out_max_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_none  = out_none_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_max_argmax_stream.sv
// Directed bench for max_argmax_stream: a default instance (IDX_W=10) and a narrow
// one (IDX_W=4) for index wrap/overflow.
module tb_max_argmax_stream;
    localparam int unsigned W    = 16;
    localparam int unsigned P    = 8;
    localparam int unsigned IDXW = 10;
    localparam int unsigned IDXN = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;

    always #5 clk = ~clk;

    max_argmax_stream_if #(.W(W), .P(P), .IDX_W(IDXW)) b0 ();
    max_argmax_stream_if #(.W(W), .P(P), .IDX_W(IDXN)) b1 ();

    max_argmax_stream #(.W(W), .P(P), .IDX_W(IDXW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (b0)
    );

    max_argmax_stream #(.W(W), .P(P), .IDX_W(IDXN)) u_dut_narrow (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (b1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [P*W-1:0] pack8(
        input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2,
        input logic [W-1:0] d3, input logic [W-1:0] d4, input logic [W-1:0] d5,
        input logic [W-1:0] d6, input logic [W-1:0] d7);
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    // Call just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input bit sel, input logic [P-1:0] mask,
                             input logic [P*W-1:0] data, input logic last);
        bit done;
        done = 1'b0;
        if (!sel) begin
            b0.in_valid = 1'b1; b0.in_lane_valid = mask; b0.in_data = data; b0.in_last = last;
        end else begin
            b1.in_valid = 1'b1; b1.in_lane_valid = mask; b1.in_data = data; b1.in_last = last;
        end
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            done = sel ? b1.in_ready : b0.in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check_eq("send timeout", 32'd0, 32'd1);
        if (!sel) b0.in_valid = 1'b0;
        else      b1.in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; lat counts falling edges from the call.
    task automatic get_result(input bit sel, output logic [31:0] mx, output logic [31:0] ix,
                              output logic nn, output logic ov, output int lat);
        lat = 0; mx = '0; ix = '0; nn = 1'b0; ov = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!sel && b0.out_valid) begin
                lat = c; mx = 32'(b0.out_max); ix = 32'(b0.out_idx);
                nn = b0.out_none; ov = b0.out_ovf;
                break;
            end
            if (sel && b1.out_valid) begin
                lat = c; mx = 32'(b1.out_max); ix = 32'(b1.out_idx);
                nn = b1.out_none; ov = b1.out_ovf;
                break;
            end
        end
        if (lat == 0) check_eq("result timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] mx, ix;
    logic        nn, ov;
    int          lat;
    logic [31:0] bp_max [3];
    logic [31:0] bp_idx [3];
    int          bp_cnt;
    int          seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b0.in_valid = 1'b1; b0.in_last = 1'b1; b0.in_lane_valid = '1;
        b0.in_data  = pack8(0, 0, 0, 0, 0, 0, 0, 16'h7FFF);
        b0.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_last = 1'b0; b1.in_lane_valid = '0; b1.in_data = '0;
        b1.out_ready = 1'b1;

        // Reset state; the beat presented during reset must be discarded.
        #2;
        check_eq("reset out_valid", 32'(b0.out_valid), 32'd0);
        check_eq("reset out_max", 32'(b0.out_max), 32'd0);
        check_eq("reset out_idx", 32'(b0.out_idx), 32'd0);
        check_eq("reset flags", {30'd0, b0.out_none, b0.out_ovf}, 32'd0);
        check_eq("reset in_ready", 32'(b0.in_ready), 32'd1);
        #18;
        b0.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, tie between lanes 2 and 4.
        send_beat(0, 8'hFF, pack8(16'h0400, 16'hFC00, 16'h0C00, 16'h0100,
                                  16'h0C00, 16'h0000, 16'h0000, 16'h8000), 1'b1);
        get_result(0, mx, ix, nn, ov, lat);
        check_eq("t1 max", mx, 32'h0C00);
        check_eq("t1 idx", ix, 32'd2);
        check_eq("t1 none", 32'(nn), 32'd0);
        check_eq("t1 ovf", 32'(ov), 32'd0);
        check_eq("t1 latency", 32'(lat), 32'd4);

        // Three beats, tie across beats keeps the earlier index.
        send_beat(0, 8'hFF, pack8(16'h0100, 16'h0100, 16'h0100, 16'h0100,
                                  16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b0);
        send_beat(0, 8'hFF, pack8(16'h0200, 16'h0200, 16'h0200, 16'h0200,
                                  16'h0200, 16'h1000, 16'h0200, 16'h0200), 1'b0);
        send_beat(0, 8'hFF, pack8(16'h1000, 16'h0300, 16'h0300, 16'h0300,
                                  16'h0300, 16'h0300, 16'h0300, 16'h0300), 1'b1);
        get_result(0, mx, ix, nn, ov, lat);
        check_eq("t2 max", mx, 32'h1000);
        check_eq("t2 idx", ix, 32'd13);

        // Masked lanes carry large values that must be ignored.
        send_beat(0, 8'h00, pack8(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                                  16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b0);
        send_beat(0, 8'h10, pack8(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                                  16'hF800, 16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b1);
        get_result(0, mx, ix, nn, ov, lat);
        check_eq("t3 max", mx, 32'hF800);
        check_eq("t3 idx", ix, 32'd12);
        check_eq("t3 none", 32'(nn), 32'd0);

        send_beat(0, 8'h00, pack8(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                                  16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b0);
        send_beat(0, 8'h00, pack8(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                                  16'hF800, 16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b1);
        get_result(0, mx, ix, nn, ov, lat);
        check_eq("t3b none", 32'(nn), 32'd1);
        check_eq("t3b max", mx, 32'd0);
        check_eq("t3b idx", ix, 32'd0);

        // Enable low for six cycles freezes the pipe mid-flight.
        send_beat(0, 8'hFF, pack8(16'h0011, 16'h0011, 16'h0011, 16'h0011,
                                  16'h0011, 16'h0555, 16'h0011, 16'h0011), 1'b1);
        @(posedge clk);
        #2 en = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (b0.out_valid) seen++;
        end
        check_eq("en low in_ready", 32'(b0.in_ready), 32'd0);
        check_eq("en low no result", 32'(seen), 32'd0);
        @(posedge clk);
        #2 en = 1'b1;
        get_result(0, mx, ix, nn, ov, lat);
        check_eq("en idx", ix, 32'd5);
        check_eq("en remaining latency", 32'(lat), 32'd3);

        // Back-pressure: three vectors stream in while the first result is held.
        b0.out_ready = 1'b0;
        bp_cnt = 0;
        fork
            begin
                send_beat(0, 8'hFF, pack8(0, 0, 0, 16'h0123, 0, 0, 0, 0), 1'b1);
                send_beat(0, 8'hFF, pack8(0, 0, 0, 0, 0, 0, 0, 16'h0200), 1'b0);
                send_beat(0, 8'hFF, pack8(16'h0010, 16'h0010, 16'h0010, 16'h0010,
                                          16'h0010, 16'h0010, 16'h0010, 16'h0010), 1'b1);
                send_beat(0, 8'hFF, pack8(16'h8000, 16'hFFFF, 16'h8000, 16'h8000,
                                          16'h8000, 16'h8000, 16'h8000, 16'h8000), 1'b1);
            end
            begin
                seen = 0;
                for (int c = 0; c < 40 && seen == 0; c++) begin
                    @(negedge clk);
                    if (b0.out_valid) seen = 1;
                end
                check_eq("bp first valid", 32'(seen), 32'd1);
                check_eq("bp in_ready stall", 32'(b0.in_ready), 32'd0);
                repeat (8) @(negedge clk);
                check_eq("bp held valid", 32'(b0.out_valid), 32'd1);
                check_eq("bp held max", 32'(b0.out_max), 32'h0123);
                check_eq("bp held idx", 32'(b0.out_idx), 32'd3);
                @(posedge clk);
                #2 b0.out_ready = 1'b1;
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    if (b0.out_valid) begin
                        if (bp_cnt < 3) begin
                            bp_max[bp_cnt] = 32'(b0.out_max);
                            bp_idx[bp_cnt] = 32'(b0.out_idx);
                        end
                        bp_cnt++;
                    end
                end
            end
        join
        @(posedge clk);
        #1;
        check_eq("bp result count", 32'(bp_cnt), 32'd3);
        check_eq("bp r0 max", bp_max[0], 32'h0123);
        check_eq("bp r1 max", bp_max[1], 32'h0200);
        check_eq("bp r1 idx", bp_idx[1], 32'd7);
        check_eq("bp r2 max", bp_max[2], 32'hFFFF);
        check_eq("bp r2 idx", bp_idx[2], 32'd1);

        // Narrow index: 3 beats overflow 16 slots, index wraps.
        send_beat(1, 8'hFF, pack8(1, 1, 1, 1, 1, 1, 1, 1), 1'b0);
        send_beat(1, 8'hFF, pack8(2, 2, 2, 2, 2, 2, 2, 2), 1'b0);
        send_beat(1, 8'hFF, pack8(0, 0, 0, 0, 0, 0, 16'h0500, 0), 1'b1);
        get_result(1, mx, ix, nn, ov, lat);
        check_eq("ovf max", mx, 32'h0500);
        check_eq("ovf idx", ix, 32'd6);
        check_eq("ovf flag", 32'(ov), 32'd1);
        send_beat(1, 8'hFF, pack8(0, 0, 5, 0, 0, 0, 0, 0), 1'b0);
        send_beat(1, 8'hFF, pack8(0, 7, 0, 0, 0, 0, 0, 0), 1'b1);
        get_result(1, mx, ix, nn, ov, lat);
        check_eq("no ovf idx", ix, 32'd9);
        check_eq("no ovf flag", 32'(ov), 32'd0);

        // Reset mid-vector with a result held.
        b0.out_ready = 1'b0;
        send_beat(0, 8'hFF, pack8(0, 0, 16'h0222, 0, 0, 0, 0, 0), 1'b1);
        send_beat(0, 8'hFF, pack8(16'h0300, 16'h0300, 16'h0300, 16'h0300,
                                  16'h0300, 16'h0300, 16'h0300, 16'h0300), 1'b0);
        send_beat(0, 8'hFF, pack8(16'h0300, 16'h0300, 16'h0300, 16'h0300,
                                  16'h0300, 16'h0300, 16'h0300, 16'h0300), 1'b0);
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            @(negedge clk);
            if (b0.out_valid) seen = 1;
        end
        check_eq("rst pre valid", 32'(seen), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst async valid", 32'(b0.out_valid), 32'd0);
        check_eq("rst async max", 32'(b0.out_max), 32'd0);
        check_eq("rst async idx", 32'(b0.out_idx), 32'd0);
        check_eq("rst in_ready", 32'(b0.in_ready), 32'd1);
        b0.out_ready = 1'b1;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(0, 8'hFF, pack8(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
                                  16'h0044, 16'hFF00, 16'hFF00, 16'hFF00), 1'b1);
        get_result(0, mx, ix, nn, ov, lat);
        check_eq("post rst max", mx, 32'h0044);
        check_eq("post rst idx", ix, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/max_argmax_stream.md
# max_argmax_stream

Streaming, parametrised successor to the fixed-width max reduction used ahead of the Q6.10 softmax exponent stage. It accepts a vector as a sequence of P-lane beats with per-lane valid masks, and reduces it through a pipelined comparison tree plus a running accumulator. It emits the maximum value, its element index (argmax) and status flags once per vector, under a valid/ready handshake with output back-pressure. The softmax front end uses it to subtract the row maximum from rows longer than one beat.

## Interface
- W, 16: data width, signed two's complement (Q6.10 at default).
- P, 8: lanes per beat; power of two, ≥2.
- IDX_W, 10: argmax index width; must be ≥ log2(P).
- clk  in  1: single clock, rising edge.
- rst_n  in  1: one clock; reset is asynchronous and active-low.
- en  in  1: global enable; low freezes every register and forces in_ready low.
- in_valid  in  1: beat present.
- in_ready  out  1: beat accepted when in_valid & in_ready.
- in_last  in  1: final beat of the current vector.
- in_lane_valid  in  P: per-lane mask; 0 lanes are excluded from the reduction.
- in_data  in  P*W: lane i at [i*W +: W].
- out_valid  out  1: result held.
- out_ready  in  1: downstream accepts the result.
- out_max  out  W: vector maximum.
- out_idx  out  IDX_W: global index (beat_number*P + lane) of the maximum.
- out_none  out  1: no lane was valid in the whole vector.
- out_ovf  out  1: vector held more than 2^IDX_W element slots.

## Operation
- The stall condition is stall = out_valid & ~out_ready. Advance = en & ~stall. in_ready = advance, combinational. Every pipeline register updates only on advance.
- Tree: log2(P) registered stages. Each node carries {valid, value, lane index}.
- Node rule when both inputs are valid: pick A if A ≥ B (signed), else B. Ties therefore go to the lower lane.
- Node rule when one input is valid: pick that input.
- Node rule when neither input is valid: output valid is 0.
- A beat-level valid and last bit travel alongside the tree, with matching latency.
- Beat counter: increments on each accepted beat. It clears after an accepted in_last beat.
- Beat counter width is IDX_W − log2(P) bits and it wraps. The global index is {beat_count, lane}, sampled at entry.
- out_ovf is set if the counter wraps within a vector.
- Accumulator: {acc_valid, acc_max, acc_idx, acc_any}.
- On a tree-output beat with the accumulator empty (first beat of a vector), load the node result.
- Otherwise, replace the stored value only if the node is valid and node > acc_max (strict). The earliest index is therefore kept on ties across beats.
- On a beat tagged last: move the merged result (including the current beat) into the output registers and set out_valid. Clear the accumulator in the same cycle.
- out_none = 1 when no valid lane was seen. In that case out_max = 0 and out_idx = 0.
- Output: held stable while out_valid & ~out_ready. It clears on out_valid & out_ready unless a new last beat loads in the same cycle.
- Single-beat vectors (in_last on first beat) are legal. Back-to-back vectors need no idle cycles.

## Timing
- Latency: an accepted last beat at cycle t gives out_valid at t + log2(P) + 1. That is 4 cycles at P=8.
- Throughput: one beat per cycle while out_ready = 1 or out_valid = 0.
- Stall propagates through the whole pipe in the same cycle. No beat is dropped or duplicated.
- Reset (async assert) values:
  - out_valid = 0, out_max = 0, out_idx = 0, out_none = 0, out_ovf = 0.
  - All tree, accumulator and counter state = 0.
- in_ready equals en during reset, but beats presented while rst_n = 0 are discarded.
- Reset mid-vector: the partial vector is lost. The first beat accepted after release starts a new vector at index 0.
- en low: all state holds, including out_valid. Handshakes resume unchanged when en returns.
- Simultaneous out_ready and a new result: the new result replaces the old one without a gap cycle.

## Test plan
- P=8, one beat, all lanes valid, data 0x0400, 0xFC00, 0x0C00, 0x0100, 0x0C00, 0, 0, 0x8000, in_last=1 → after 4 cycles: out_max=0x0C00, out_idx=2 (tie goes to the lower lane), out_none=0.
- Three-beat vector with beat-1 lane 5 = 0x1000 and beat-2 lane 0 = 0x1000, all others below → out_max=0x1000, out_idx=13.
- Mask test: lane_valid=0x00 on beat 0, then 0x10 on beat 1 with lane 4 = 0xF800 (−2.0), last → out_max=0xF800, out_idx=12. The same vector with both masks 0 → out_none=1, out_max=0, out_idx=0.
- Back-pressure: hold out_ready=0 after a result while streaming two more vectors → in_ready drops the same cycle out_valid rises and the first result stays stable. Releasing out_ready gives results in order with no loss.
- IDX_W=4, P=8, a 3-beat vector → out_ovf=1 and the index wraps modulo 16.
- Assert rst_n low mid-vector with out_valid=1 → all outputs read 0 asynchronously. A following single-beat vector reports out_idx equal to its lane only.
